camera_step_sequencer: RTL and testbench

Applies one camera motion step per rate tick to a working camera state using a single shared pipelined fixed-point multiplier. Each step replaces a bank of parallel `fp_mul` instances. Completed steps are published to the ray-marcher only on frame boundaries, so one frame always renders from a single consistent pos/dir pair. The block sits between the button/switch inputs and the ray-marcher core's camera inputs.

---
 rtl/camera_step_sequencer_pkg.sv | 56 +++++
 rtl/camera_step_sequencer_fp_mul_pipe.sv | 43 ++++
 rtl/camera_step_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_camera_step_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_step_sequencer_pkg.sv
// Fixed-point camera types, motion constants and arithmetic helpers shared by
// the camera step sequencer and its multiplier pipe.
package camera_step_sequencer_pkg;
  localparam int unsigned FP_W    = 32;
  localparam int unsigned FP_FRAC = 16;

  typedef logic signed [FP_W-1:0] fp_t;
  typedef struct packed {
    fp_t x;
    fp_t y;
    fp_t z;
  } vec3_t;

  localparam fp_t FP_ZERO          = '0;
  localparam fp_t FP_ONE           = 32'sd65536;
  localparam fp_t FP_THREE_HALFS   = 32'sd98304;
  localparam fp_t FP_HUNDREDTH     = 32'sd655;
  localparam fp_t FP_COS_HUNDREDTH = 32'sd65533;
  localparam fp_t FP_SIN_HUNDREDTH = 32'sd655;

  localparam vec3_t POS_INIT = '{x: FP_ZERO, y: FP_ONE, z: -FP_THREE_HALFS};
  localparam vec3_t DIR_INIT = '{x: FP_ZERO, y: FP_ZERO, z: FP_ONE};

  typedef enum logic [1:0] {
    MODE_WALK   = 2'd0,
    MODE_TRANS  = 2'd1,
    MODE_HOLD_A = 2'd2,
    MODE_HOLD_B = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_COMMIT
  } state_e;

  // Product is truncated toward minus infinity (arithmetic shift).
  function automatic fp_t fp_mul(input fp_t a, input fp_t b);
    logic signed [2*FP_W-1:0] p;
    p = (2*FP_W)'(a) * (2*FP_W)'(b);
    return fp_t'(p >>> FP_FRAC);
  endfunction

  function automatic fp_t fp_add(input fp_t a, input fp_t b);
    return a + b;
  endfunction

  function automatic fp_t fp_sub(input fp_t a, input fp_t b);
    return a - b;
  endfunction

  function automatic fp_t fp_neg(input fp_t a);
    return -a;
  endfunction
endpackage

// File: rtl/camera_step_sequencer_fp_mul_pipe.sv
// Registered fixed-point multiplier, MUL_LAT stages deep, carrying a valid bit
// and a slot tag alongside each product. Never stalls.
module fp_mul_pipe
  import camera_step_sequencer_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       i_valid,
  input  logic [2:0] i_tag,
  input  fp_t        i_a,
  input  fp_t        i_b,
  output logic       o_valid,
  output logic [2:0] o_tag,
  output fp_t        o_p
);
  logic       r_valid [MUL_LAT];
  logic [2:0] r_tag   [MUL_LAT];
  fp_t        r_p     [MUL_LAT];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < MUL_LAT; i++) r_valid[i] <= 1'b0;
    end else begin
      r_valid[0] <= i_valid;
      for (int unsigned i = 1; i < MUL_LAT; i++) r_valid[i] <= r_valid[i-1];
    end
  end

  always_ff @(posedge clk_in) begin
    r_tag[0] <= i_tag;
    r_p[0]   <= fp_mul(i_a, i_b);
    for (int unsigned i = 1; i < MUL_LAT; i++) begin
      r_tag[i] <= r_tag[i-1];
      r_p[i]   <= r_p[i-1];
    end
  end

  assign o_valid = r_valid[MUL_LAT-1];
  assign o_tag   = r_tag[MUL_LAT-1];
  assign o_p     = r_p[MUL_LAT-1];
endmodule

// File: rtl/camera_step_sequencer.sv
// Applies one camera motion step per tick through a shared multiplier and
// publishes the working camera to the renderer only on frame boundaries.
module camera_step_sequencer
  import camera_step_sequencer_pkg::*;
#(
  parameter int unsigned MUL_LAT   = 2,
  parameter int unsigned EPS_BITS  = 7,
  parameter int unsigned DROP_BITS = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 tick_in,
  input  logic                 btnl,
  input  logic                 btnr,
  input  logic                 btnu,
  input  logic                 btnd,
  input  logic [1:0]           mode_in,
  input  logic                 frame_done_in,
  output vec3_t                pos_out,
  output vec3_t                dir_out,
  output logic                 busy_out,
  output logic                 pending_out,
  output logic [DROP_BITS-1:0] dropped_out
);
  localparam int unsigned DW  = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam fp_t         EPS = FP_ONE >>> EPS_BITS;

  state_e r_state, w_state_nxt;
  logic r_btnl, r_btnr, r_btnu, r_btnd;
  mode_e r_mode;
  logic [2:0] r_idx, r_last;
  logic [DW-1:0] r_drain;
  fp_t r_prod [6];
  vec3_t r_pos, r_dir, r_pub_pos, r_pub_dir;
  logic r_pending;
  logic [DROP_BITS-1:0] r_dropped;

  logic w_move, w_rot, w_has_prod, w_vert_only;
  logic [2:0] w_first, w_last;
  logic w_busy, w_issue, w_accept, w_commit;
  logic w_snap_mv, w_snap_rt;
  fp_t w_s, w_op_a, w_op_b;
  vec3_t w_pos_nxt, w_dir_nxt;
  logic w_mul_valid;
  logic [2:0] w_mul_tag;
  fp_t w_mul_p;

  // Products occupy fixed slots; each step issues one contiguous slot range.
  always_comb begin
    w_move      = btnu ^ btnd;
    w_rot       = btnl ^ btnr;
    w_has_prod  = 1'b0;
    w_vert_only = 1'b0;
    w_first     = 3'd0;
    w_last      = 3'd1;
    case (mode_e'(mode_in))
      MODE_WALK: begin
        w_has_prod = w_move | w_rot;
        w_first    = w_move ? 3'd0 : 3'd2;
        w_last     = w_rot ? 3'd5 : 3'd1;
      end
      MODE_TRANS: begin
        w_has_prod  = w_rot;
        w_vert_only = w_move & ~w_rot;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (tick_in && w_has_prod)       w_state_nxt = ST_ISSUE;
        else if (tick_in && w_vert_only) w_state_nxt = ST_COMMIT;
      end
      ST_ISSUE:  if (r_idx == r_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN:  if (r_drain == DW'(MUL_LAT - 1)) w_state_nxt = ST_COMMIT;
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = (r_state != ST_IDLE);
    w_issue  = (r_state == ST_ISSUE);
    w_accept = (r_state == ST_IDLE) && tick_in;
    w_commit = (r_state == ST_COMMIT);
  end

  always_comb begin
    w_s    = r_btnr ? FP_SIN_HUNDREDTH : fp_neg(FP_SIN_HUNDREDTH);
    w_op_a = r_dir.x;
    w_op_b = FP_HUNDREDTH;
    if (r_mode == MODE_TRANS) begin
      w_op_a = r_idx[0] ? r_dir.x : r_dir.z;
    end else begin
      case (r_idx)
        3'd1: w_op_a = r_dir.z;
        3'd2: w_op_b = FP_COS_HUNDREDTH;
        3'd3: begin w_op_a = r_dir.z; w_op_b = w_s;         end
        3'd4: w_op_b = fp_neg(w_s);
        3'd5: begin w_op_a = r_dir.z; w_op_b = FP_COS_HUNDREDTH; end
        default: ;
      endcase
    end
  end

  fp_mul_pipe #(.MUL_LAT(MUL_LAT)) u_mul (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .i_valid (w_issue),
    .i_tag   (r_idx),
    .i_a     (w_op_a),
    .i_b     (w_op_b),
    .o_valid (w_mul_valid),
    .o_tag   (w_mul_tag),
    .o_p     (w_mul_p)
  );

  always_comb begin
    w_pos_nxt = r_pos;
    w_dir_nxt = r_dir;
    w_snap_mv = r_btnu ^ r_btnd;
    w_snap_rt = r_btnl ^ r_btnr;
    if (r_mode == MODE_WALK) begin
      if (w_snap_mv) begin
        w_pos_nxt.x = r_btnu ? fp_add(r_pos.x, r_prod[0]) : fp_sub(r_pos.x, r_prod[0]);
        w_pos_nxt.z = r_btnu ? fp_add(r_pos.z, r_prod[1]) : fp_sub(r_pos.z, r_prod[1]);
      end
      if (w_snap_rt) begin
        w_dir_nxt.x = fp_add(r_prod[2], r_prod[3]);
        w_dir_nxt.z = fp_add(r_prod[4], r_prod[5]);
      end
    end else if (r_mode == MODE_TRANS) begin
      if (w_snap_rt) begin
        w_pos_nxt.x = r_btnr ? fp_add(r_pos.x, r_prod[0]) : fp_sub(r_pos.x, r_prod[0]);
        w_pos_nxt.z = r_btnr ? fp_sub(r_pos.z, r_prod[1]) : fp_add(r_pos.z, r_prod[1]);
      end
      if (w_snap_mv) w_pos_nxt.y = r_btnu ? fp_add(r_pos.y, EPS) : fp_sub(r_pos.y, EPS);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      {r_btnl, r_btnr, r_btnu, r_btnd} <= '0;
      r_mode    <= MODE_WALK;
      r_idx     <= '0;
      r_last    <= '0;
      r_drain   <= '0;
      r_pos     <= POS_INIT;
      r_dir     <= DIR_INIT;
      r_pub_pos <= POS_INIT;
      r_pub_dir <= DIR_INIT;
      r_pending <= 1'b0;
      r_dropped <= '0;
    end else begin
      if (w_accept) begin
        {r_btnl, r_btnr, r_btnu, r_btnd} <= {btnl, btnr, btnu, btnd};
        r_mode <= mode_e'(mode_in);
        r_idx  <= w_first;
        r_last <= w_last;
      end
      if (w_issue) begin
        r_idx   <= r_idx + 3'd1;
        r_drain <= '0;
      end else if (r_state == ST_DRAIN) begin
        r_drain <= r_drain + 1'b1;
      end
      if (w_commit) begin
        r_pos <= w_pos_nxt;
        r_dir <= w_dir_nxt;
      end
      // Publishing reads the pre-commit work values even in the COMMIT cycle.
      if (frame_done_in && r_pending) begin
        r_pub_pos <= r_pos;
        r_pub_dir <= r_dir;
      end
      if (w_commit)           r_pending <= 1'b1;
      else if (frame_done_in) r_pending <= 1'b0;
      if (tick_in && w_busy && (r_dropped != '1)) r_dropped <= r_dropped + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_mul_valid) r_prod[w_mul_tag] <= w_mul_p;
  end

  assign pos_out     = r_pub_pos;
  assign dir_out     = r_pub_dir;
  assign busy_out    = w_busy;
  assign pending_out = r_pending;
  assign dropped_out = r_dropped;
endmodule

// File: tb/tb_camera_step_sequencer.sv
// Self-checking bench for camera_step_sequencer: directed scenarios plus a
// randomized run, all checked against a step-level camera model.
module tb_camera_step_sequencer;
  import camera_step_sequencer_pkg::*;

  localparam int unsigned LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic bl = 1'b0, br = 1'b0, bu = 1'b0, bd = 1'b0;
  logic [1:0] mode = 2'd0;
  logic fd = 1'b0;
  vec3_t pos_o, dir_o;
  logic busy_o, pend_o;
  logic [7:0] drop_o;

  int n_cmp = 0;
  int n_err = 0;

  // Constants derived from their real-valued definitions in Q16.16.
  int K_ONE, K_H, K_C, K_S, K_EPS;

  int m_pos[3], m_dir[3], m_ppos[3], m_pdir[3], m_npos[3], m_ndir[3];
  int m_busy, m_drop;
  bit m_pend;

  always #5 clk = ~clk;

  camera_step_sequencer #(.MUL_LAT(LAT), .EPS_BITS(7), .DROP_BITS(8)) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .tick_in       (tick),
    .btnl          (bl),
    .btnr          (br),
    .btnu          (bu),
    .btnd          (bd),
    .mode_in       (mode),
    .frame_done_in (fd),
    .pos_out       (pos_o),
    .dir_out       (dir_o),
    .busy_out      (busy_o),
    .pending_out   (pend_o),
    .dropped_out   (drop_o)
  );

  function automatic int mul(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    return int'(p >>> 16);
  endfunction

  function automatic vec3_t mk(input int x, input int y, input int z);
    vec3_t v;
    v.x = x;
    v.y = y;
    v.z = z;
    return v;
  endfunction

  task automatic model_reset();
    m_pos  = '{0, K_ONE, -(K_ONE + K_ONE / 2)};
    m_dir  = '{0, 0, K_ONE};
    m_ppos = m_pos;
    m_pdir = m_dir;
    m_busy = 0;
    m_drop = 0;
    m_pend = 1'b0;
  endtask

  // Computes the camera after one step and how many cycles the step is busy.
  task automatic plan_step(input logic [1:0] md, input bit l, input bit r,
                           input bit u, input bit d, output int len);
    int n, s;
    bit mv, rt;
    mv = u ^ d;
    rt = l ^ r;
    s = r ? K_S : -K_S;
    n = 0;
    len = 0;
    m_npos = m_pos;
    m_ndir = m_dir;
    if (md == 2'd0) begin
      if (mv) begin
        n += 2;
        m_npos[0] = u ? m_pos[0] + mul(m_dir[0], K_H) : m_pos[0] - mul(m_dir[0], K_H);
        m_npos[2] = u ? m_pos[2] + mul(m_dir[2], K_H) : m_pos[2] - mul(m_dir[2], K_H);
      end
      if (rt) begin
        n += 4;
        m_ndir[0] = mul(m_dir[0], K_C) + mul(m_dir[2], s);
        m_ndir[2] = mul(m_dir[0], -s) + mul(m_dir[2], K_C);
      end
      if (n > 0) len = n + LAT + 1;
    end else if (md == 2'd1) begin
      if (rt) begin
        n = 2;
        m_npos[0] = r ? m_pos[0] + mul(m_dir[2], K_H) : m_pos[0] - mul(m_dir[2], K_H);
        m_npos[2] = r ? m_pos[2] - mul(m_dir[0], K_H) : m_pos[2] + mul(m_dir[0], K_H);
      end
      if (mv) m_npos[1] = u ? m_pos[1] + K_EPS : m_pos[1] - K_EPS;
      len = (n > 0) ? n + LAT + 1 : (mv ? 1 : 0);
    end
  endtask

  task automatic clk_cycle();
    int len;
    bit commit_now;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      commit_now = (m_busy == 1);
      if (fd && m_pend) begin
        m_ppos = m_pos;
        m_pdir = m_dir;
      end
      if (commit_now)  m_pend = 1'b1;
      else if (fd)     m_pend = 1'b0;
      if (commit_now) begin
        m_pos = m_npos;
        m_dir = m_ndir;
      end
      if (m_busy > 0) begin
        if (tick && m_drop < 255) m_drop++;
        m_busy--;
      end else if (tick) begin
        plan_step(mode, bl, br, bu, bd, len);
        m_busy = len;
      end
    end
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    {tick, bl, br, bu, bd, fd} = '0;
    mode = 2'd0;
    clk_cycle();
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && busy_o; i++) clk_cycle();
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL wait_idle: busy_out=%b after 50 cycles, required 0", busy_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) clk_cycle();
    rst = 1'b0;
    clk_cycle();
    n_cmp++;
    if (pos_o !== mk(0, K_ONE, -98304)) begin
      n_err++; $display("FAIL reset_pos: got %h required %h", pos_o, mk(0, K_ONE, -98304));
    end
    n_cmp++;
    if (dir_o !== mk(0, 0, K_ONE)) begin
      n_err++; $display("FAIL reset_dir: got %h required %h", dir_o, mk(0, 0, K_ONE));
    end
    n_cmp++;
    if ({busy_o, pend_o, drop_o} !== 10'd0) begin
      n_err++; $display("FAIL reset_flags: busy=%b pend=%b drop=%0d required 0/0/0", busy_o, pend_o, drop_o);
    end
  endtask

  task automatic test_walk_forward();
    int busy_cnt;
    reset_dut();
    mode = 2'd0; bu = 1'b1; tick = 1'b1;
    clk_cycle();
    tick = 1'b0; bu = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 40 && busy_o; i++) begin
      busy_cnt++;
      clk_cycle();
    end
    n_cmp++;
    if (busy_cnt != 2 + LAT + 1) begin
      n_err++; $display("FAIL walk_busy_len: got %0d required %0d", busy_cnt, 2 + LAT + 1);
    end
    n_cmp++;
    if (pend_o !== 1'b1 || pos_o !== mk(0, K_ONE, -98304)) begin
      n_err++; $display("FAIL walk_prepublish: pend=%b pos=%h required 1 and %h", pend_o, pos_o, mk(0, K_ONE, -98304));
    end
    fd = 1'b1;
    clk_cycle();
    fd = 1'b0;
    n_cmp++;
    if (pos_o !== mk(0, K_ONE, -98304 + mul(K_ONE, K_H))) begin
      n_err++; $display("FAIL walk_pos: got %h required %h", pos_o, mk(0, K_ONE, -98304 + mul(K_ONE, K_H)));
    end
    n_cmp++;
    if (pend_o !== 1'b0) begin
      n_err++; $display("FAIL walk_pend_clear: got %b required 0", pend_o);
    end
  endtask

  task automatic test_rotate();
    for (int side = 0; side < 2; side++) begin
      reset_dut();
      mode = 2'd0; br = (side == 0); bl = (side == 1); tick = 1'b1;
      clk_cycle();
      tick = 1'b0; br = 1'b0; bl = 1'b0;
      wait_idle();
      fd = 1'b1;
      clk_cycle();
      fd = 1'b0;
      n_cmp++;
      if (dir_o !== mk(side == 0 ? K_S : -K_S, 0, K_C)) begin
        n_err++; $display("FAIL rotate_dir side=%0d: got %h required %h", side, dir_o, mk(side == 0 ? K_S : -K_S, 0, K_C));
      end
      n_cmp++;
      if (pos_o !== mk(0, K_ONE, -98304)) begin
        n_err++; $display("FAIL rotate_pos side=%0d: got %h required %h", side, pos_o, mk(0, K_ONE, -98304));
      end
    end
  endtask

  task automatic test_vertical();
    reset_dut();
    mode = 2'd1; bu = 1'b1; tick = 1'b1;
    clk_cycle();
    tick = 1'b0; bu = 1'b0;
    n_cmp++;
    if (busy_o !== 1'b1) begin
      n_err++; $display("FAIL vert_commit_cycle: busy=%b required 1", busy_o);
    end
    clk_cycle();
    n_cmp++;
    if (busy_o !== 1'b0 || pend_o !== 1'b1 || pos_o.y !== K_ONE) begin
      n_err++; $display("FAIL vert_after_commit: busy=%b pend=%b y=%h required 0/1/%h", busy_o, pend_o, pos_o.y, K_ONE);
    end
    fd = 1'b1;
    clk_cycle();
    fd = 1'b0;
    n_cmp++;
    if (pos_o !== mk(0, K_ONE + K_EPS, -98304)) begin
      n_err++; $display("FAIL vert_pos: got %h required %h", pos_o, mk(0, K_ONE + K_EPS, -98304));
    end
  endtask

  task automatic test_fd_commit();
    reset_dut();
    mode = 2'd0; bu = 1'b1; tick = 1'b1;
    clk_cycle();
    tick = 1'b0;
    wait_idle();
    tick = 1'b1;
    clk_cycle();
    tick = 1'b0;
    for (int i = 0; i < 40 && m_busy != 1; i++) clk_cycle();
    fd = 1'b1;
    clk_cycle();
    fd = 1'b0; bu = 1'b0;
    n_cmp++;
    if (pos_o !== mk(0, K_ONE, -98304 + K_H) || pend_o !== 1'b1) begin
      n_err++; $display("FAIL fd_in_commit: pos=%h pend=%b required %h/1", pos_o, pend_o, mk(0, K_ONE, -98304 + K_H));
    end
    fd = 1'b1;
    clk_cycle();
    fd = 1'b0;
    n_cmp++;
    if (pos_o !== mk(0, K_ONE, -98304 + 2 * K_H) || pend_o !== 1'b0) begin
      n_err++; $display("FAIL fd_after_commit: pos=%h pend=%b required %h/0", pos_o, pend_o, mk(0, K_ONE, -98304 + 2 * K_H));
    end
  endtask

  task automatic test_dropped();
    reset_dut();
    mode = 2'd0; bu = 1'b1; br = 1'b1; tick = 1'b1;
    clk_cycle();
    tick = 1'b0;
    repeat (2) clk_cycle();
    tick = 1'b1;
    clk_cycle();
    tick = 1'b0;
    n_cmp++;
    if (drop_o !== 8'd1) begin
      n_err++; $display("FAIL drop_one: got %0d required 1", drop_o);
    end
    wait_idle();
    tick = 1'b1;
    repeat (400) clk_cycle();
    tick = 1'b0;
    n_cmp++;
    if (drop_o !== 8'd255) begin
      n_err++; $display("FAIL drop_saturate: got %0d required 255", drop_o);
    end
    n_cmp++;
    if (drop_o !== 8'(m_drop)) begin
      n_err++; $display("FAIL drop_model: got %0d required %0d", drop_o, m_drop);
    end
    bu = 1'b0; br = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset_drain();
    reset_dut();
    mode = 2'd0; bu = 1'b1; tick = 1'b1;
    clk_cycle();
    tick = 1'b0; bu = 1'b0;
    repeat (2) clk_cycle();
    rst = 1'b1;
    clk_cycle();
    rst = 1'b0;
    n_cmp++;
    if (pos_o !== mk(0, K_ONE, -98304) || dir_o !== mk(0, 0, K_ONE) || {busy_o, pend_o, drop_o} !== 10'd0) begin
      n_err++; $display("FAIL drain_reset: pos=%h dir=%h busy=%b pend=%b drop=%0d required reset values", pos_o, dir_o, busy_o, pend_o, drop_o);
    end
    repeat (8) clk_cycle();
    fd = 1'b1;
    clk_cycle();
    fd = 1'b0;
    n_cmp++;
    if (pos_o !== mk(0, K_ONE, -98304) || busy_o !== 1'b0 || pend_o !== 1'b0) begin
      n_err++; $display("FAIL drain_no_publish: pos=%h busy=%b pend=%b required %h/0/0", pos_o, busy_o, pend_o, mk(0, K_ONE, -98304));
    end
  endtask

  task automatic test_random();
    reset_dut();
    for (int c = 0; c < 1500; c++) begin
      tick = ($urandom_range(0, 3) == 0);
      bl = 1'($urandom_range(0, 1));
      br = 1'($urandom_range(0, 1));
      bu = 1'($urandom_range(0, 1));
      bd = 1'($urandom_range(0, 1));
      mode = 2'($urandom_range(0, 3));
      fd = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 399) == 0);
      clk_cycle();
      n_cmp++;
      if (pos_o !== mk(m_ppos[0], m_ppos[1], m_ppos[2])) begin
        n_err++; $display("FAIL rand_pos c=%0d: got %h required %h", c, pos_o, mk(m_ppos[0], m_ppos[1], m_ppos[2]));
      end
      n_cmp++;
      if (dir_o !== mk(m_pdir[0], m_pdir[1], m_pdir[2])) begin
        n_err++; $display("FAIL rand_dir c=%0d: got %h required %h", c, dir_o, mk(m_pdir[0], m_pdir[1], m_pdir[2]));
      end
      n_cmp++;
      if (busy_o !== (m_busy > 0) || pend_o !== m_pend || drop_o !== 8'(m_drop)) begin
        n_err++; $display("FAIL rand_flags c=%0d: busy=%b pend=%b drop=%0d required %b/%b/%0d", c, busy_o, pend_o, drop_o, m_busy > 0, m_pend, m_drop);
      end
    end
    {tick, bl, br, bu, bd, fd, rst} = '0;
  endtask

  initial begin
    K_ONE = 65536;
    K_H   = int'(0.01 * 65536.0);
    K_C   = int'($cos(0.01) * 65536.0);
    K_S   = int'($sin(0.01) * 65536.0);
    K_EPS = K_ONE / 128;
    model_reset();
    test_reset();
    test_walk_forward();
    test_rotate();
    test_vertical();
    test_fd_commit();
    test_dropped();
    test_reset_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
